// File: rtl/rotary_menu_ctrl.sv
// Rotary/push-button settings menu: browse items, edit values, commit into NITEM config registers.
// Optional same-direction step acceleration in EDIT is built when ROTARY_MENU_ACCEL_EN is defined.
module rotary_menu_ctrl #(
  parameter int unsigned   NITEM     = 4,
  parameter int unsigned   VW        = 8,
  parameter int unsigned   RN        = 12,
  parameter logic [VW-1:0] INIT_CFG  = '0,
  parameter int unsigned   DEB       = 200000,
  parameter int unsigned   TIMEOUT   = 50000000,
  parameter int unsigned   ACCEL_WIN = 2000000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [$clog2(RN)-1:0]    rot_cnt_i,
  input  logic                     btn_ni,
  output logic [$clog2(NITEM)-1:0] sel_o,
  output logic                     editing_o,
  output logic [VW-1:0]            edit_val_o,
  output logic [NITEM*VW-1:0]      cfg_o,
  output logic                     commit_o,
  output logic [$clog2(NITEM)-1:0] commit_idx_o
);
  localparam int unsigned RW = $clog2(RN);
  localparam int unsigned SW = $clog2(NITEM);
  localparam int unsigned DW = $clog2(DEB + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] ROT_MAX  = RW'(RN - 1);
  localparam logic [SW-1:0] SEL_MAX  = SW'(NITEM - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [VW-1:0] VAL_MAX  = '1;
  localparam logic [0:0] ST_BROWSE = 1'b0;
  localparam logic [0:0] ST_EDIT   = 1'b1;

  logic [RW-1:0] rot_prev_q, rot_up, rot_dn;
  logic          rot_valid_q, inc_q, dec_q;
  logic          btn_s1_q, btn_s2_q, btn_db_q, press_q;
  logic [DW-1:0] deb_cnt_q;
  logic [0:0]    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, commit_idx_q, commit_idx_d;
  logic [VW-1:0] edit_val_q, edit_val_d, step_sz;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          commit_q, commit_d, cfg_we;
  logic [VW-1:0] cfg_q [NITEM];

  // Neighbours of the last position, with modulo-RN wrap.
  assign rot_up = (rot_prev_q == ROT_MAX) ? '0 : rot_prev_q + RW'(1);
  assign rot_dn = (rot_prev_q == '0) ? ROT_MAX : rot_prev_q - RW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rot_prev_q  <= '0;
      rot_valid_q <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
    end else begin
      rot_prev_q  <= rot_cnt_i;
      rot_valid_q <= 1'b1;
      inc_q       <= rot_valid_q && (rot_cnt_i == rot_up);
      dec_q       <= rot_valid_q && (rot_cnt_i == rot_dn);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_s1_q  <= 1'b1;
      btn_s2_q  <= 1'b1;
      btn_db_q  <= 1'b1;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      btn_s1_q <= btn_ni;
      btn_s2_q <= btn_s1_q;
      press_q  <= 1'b0;
      if (btn_s2_q == btn_db_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        deb_cnt_q <= '0;
        btn_db_q  <= btn_s2_q;
        press_q   <= ~btn_s2_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + DW'(1);
      end
    end
  end

  // A press always wins over a step or a timeout landing in the same cycle.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    edit_val_d   = edit_val_q;
    to_cnt_d     = to_cnt_q;
    commit_d     = 1'b0;
    commit_idx_d = commit_idx_q;
    cfg_we       = 1'b0;
    if (state_q == ST_BROWSE) begin
      if (press_q) begin
        state_d    = ST_EDIT;
        edit_val_d = cfg_q[sel_q];
        to_cnt_d   = '0;
      end else if (inc_q) begin
        sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + SW'(1);
      end else if (dec_q) begin
        sel_d = (sel_q == '0) ? SEL_MAX : sel_q - SW'(1);
      end
    end else begin
      if (press_q) begin
        state_d      = ST_BROWSE;
        cfg_we       = 1'b1;
        commit_d     = 1'b1;
        commit_idx_d = sel_q;
        to_cnt_d     = '0;
      end else if (inc_q) begin
        edit_val_d = (edit_val_q > VAL_MAX - step_sz) ? VAL_MAX : edit_val_q + step_sz;
        to_cnt_d   = '0;
      end else if (dec_q) begin
        edit_val_d = (edit_val_q < step_sz) ? '0 : edit_val_q - step_sz;
        to_cnt_d   = '0;
      end else if (to_cnt_q == TO_LAST) begin
        state_d    = ST_BROWSE;
        edit_val_d = cfg_q[sel_q];
        to_cnt_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

`ifdef ROTARY_MENU_ACCEL_EN
  localparam int unsigned AW = $clog2(ACCEL_WIN + 1);
  localparam logic [AW-1:0] ACC_LAST = AW'(ACCEL_WIN - 1);
  logic [AW-1:0] acc_cnt_q;
  logic          acc_valid_q, acc_dir_q;

  // acc_cnt_q counts cycles since the previous EDIT step; acc_dir_q=1 means it was an increment.
  assign step_sz = (acc_valid_q && (acc_dir_q == inc_q) && (acc_cnt_q < ACC_LAST)) ? VW'(4) : VW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_cnt_q   <= '0;
      acc_valid_q <= 1'b0;
      acc_dir_q   <= 1'b0;
    end else if (state_q != ST_EDIT || state_d != ST_EDIT) begin
      acc_cnt_q   <= '0;
      acc_valid_q <= 1'b0;
    end else if (inc_q || dec_q) begin
      acc_cnt_q   <= '0;
      acc_valid_q <= 1'b1;
      acc_dir_q   <= inc_q;
    end else if (acc_cnt_q != ACC_LAST) begin
      acc_cnt_q <= acc_cnt_q + AW'(1);
    end
  end
`else
  logic unused_accel_win;
  assign step_sz          = VW'(1);
  assign unused_accel_win = (ACCEL_WIN == 0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_BROWSE;
      sel_q        <= '0;
      edit_val_q   <= INIT_CFG;
      to_cnt_q     <= '0;
      commit_q     <= 1'b0;
      commit_idx_q <= '0;
      for (int i = 0; i < NITEM; i++) cfg_q[i] <= INIT_CFG;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      edit_val_q   <= edit_val_d;
      to_cnt_q     <= to_cnt_d;
      commit_q     <= commit_d;
      commit_idx_q <= commit_idx_d;
      if (cfg_we) cfg_q[sel_q] <= edit_val_q;
    end
  end

  for (genvar gi = 0; gi < NITEM; gi++) begin : g_cfg_out
    assign cfg_o[gi*VW +: VW] = cfg_q[gi];
  end

  assign sel_o        = sel_q;
  assign editing_o    = (state_q == ST_EDIT);
  assign edit_val_o   = (state_q == ST_EDIT) ? edit_val_q : cfg_q[sel_q];
  assign commit_o     = commit_q;
  assign commit_idx_o = commit_idx_q;

endmodule

// File: tb/tb_rotary_menu_ctrl.sv
// Self-checking bench for rotary_menu_ctrl: table-driven browse vectors, hand-written corner
// sequences and a randomized run against an event-level model of the menu.
module tb_rotary_menu_ctrl;
  localparam int NITEM = 4, VW = 8, RN = 12, DEB = 20, TIMEOUT = 600, ACCEL_WIN = 300;
`ifdef ROTARY_MENU_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rot_cnt;
  logic        btn_n;
  logic [1:0]  sel;
  logic        editing;
  logic [7:0]  edit_val;
  logic [31:0] cfg;
  logic        commit;
  logic [1:0]  commit_idx;

  rotary_menu_ctrl #(
    .NITEM(NITEM), .VW(VW), .RN(RN), .INIT_CFG(8'd0),
    .DEB(DEB), .TIMEOUT(TIMEOUT), .ACCEL_WIN(ACCEL_WIN)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .rot_cnt_i(rot_cnt), .btn_ni(btn_n),
    .sel_o(sel), .editing_o(editing), .edit_val_o(edit_val), .cfg_o(cfg),
    .commit_o(commit), .commit_idx_o(commit_idx)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Event-level model of the menu.
  int m_sel, m_val, m_prev, m_commits, m_last_idx, m_last_dir;
  bit m_edit;
  int m_cfg [NITEM];

  // Commit pulse monitor.
  int   commit_seen = 0, commit_last_idx = 0, commit_double = 0;
  logic commit_prev = 1'b0;
  always @(negedge clk) begin
    if (commit === 1'b1) begin
      commit_seen++;
      commit_last_idx = int'(commit_idx);
      if (commit_prev === 1'b1) commit_double++;
    end
    commit_prev = commit;
  end

  typedef struct { int rot; int exp_sel; } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " sel"}, int'(sel), m_sel);
    check({tag, " editing"}, int'(editing), int'(m_edit));
    check({tag, " edit_val"}, int'(edit_val), m_edit ? m_val : m_cfg[m_sel]);
    for (int i = 0; i < NITEM; i++)
      check($sformatf("%s cfg%0d", tag, i), int'(cfg[i*VW +: VW]), m_cfg[i]);
    check({tag, " commits"}, commit_seen, m_commits);
    check({tag, " commit_idx"}, commit_last_idx, m_last_idx);
    check({tag, " commit width"}, commit_double, 0);
  endtask

  task automatic m_step(input int dir, input bit fast);
    int sz;
    if (!m_edit) begin
      m_sel = (m_sel + dir + NITEM) % NITEM;
    end else begin
      sz = (ACCEL && fast && m_last_dir == dir) ? 4 : 1;
      m_val = m_val + dir * sz;
      if (m_val > 255) m_val = 255;
      if (m_val < 0) m_val = 0;
      m_last_dir = dir;
    end
  endtask

  task automatic m_press();
    if (!m_edit) begin
      m_edit = 1'b1;
      m_val  = m_cfg[m_sel];
    end else begin
      m_cfg[m_sel] = m_val;
      m_commits++;
      m_last_idx = m_sel;
      m_edit = 1'b0;
    end
    m_last_dir = 0;
  endtask

  task automatic turn(input int pos, input int pre_wait);
    int d;
    repeat (pre_wait) @(negedge clk);
    d = (pos - m_prev + RN) % RN;
    rot_cnt = 4'(pos);
    m_prev = pos;
    if (d == 1) m_step(1, pre_wait < ACCEL_WIN / 2);
    else if (d == RN - 1) m_step(-1, pre_wait < ACCEL_WIN / 2);
    repeat (3) @(negedge clk);
  endtask

  task automatic inc(input int pre_wait);
    turn((m_prev + 1) % RN, pre_wait);
  endtask

  task automatic dec(input int pre_wait);
    turn((m_prev + RN - 1) % RN, pre_wait);
  endtask

  task automatic press();
    btn_n = 1'b0;
    repeat (DEB + 5) @(negedge clk);
    btn_n = 1'b1;
    repeat (DEB + 5) @(negedge clk);
    m_press();
  endtask

  // Step timed so it reaches the menu in the same cycle as the debounced press.
  task automatic press_with_step();
    btn_n = 1'b0;
    repeat (DEB + 1) @(negedge clk);
    m_prev = (m_prev + 1) % RN;
    rot_cnt = 4'(m_prev);
    repeat (4) @(negedge clk);
    btn_n = 1'b1;
    repeat (DEB + 5) @(negedge clk);
    m_press();
  endtask

  task automatic edit_to(input int target);
    int diff, dir, guard;
    guard = 0;
    while (m_val != target && guard < 1000) begin
      diff = target - m_val;
      dir  = (diff > 0) ? 1 : -1;
      turn((m_prev + dir + RN) % RN, (diff * dir >= 4) ? 0 : ACCEL_WIN + 10);
      guard++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{9, 2};
    tbl[1] = '{10, 3};
    tbl[2] = '{11, 0};
    tbl[3] = '{0, 1};
    tbl[4] = '{11, 0};
    tbl[5] = '{5, 0};

    rot_cnt = 4'd7;
    btn_n   = 1'b1;
    rst_n   = 1'b0;
    m_sel = 0; m_val = 0; m_prev = 7; m_commits = 0; m_last_idx = 0; m_last_dir = 0; m_edit = 1'b0;
    for (int i = 0; i < NITEM; i++) m_cfg[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all("reset");
    check("reset commit_o", int'(commit), 0);

    // Step latency: position change seen at one edge, acted on at the next.
    rot_cnt = 4'd8;
    m_prev  = 8;
    @(negedge clk);
    check("step latency +1", int'(sel), 0);
    @(negedge clk);
    check("step latency +2", int'(sel), 1);
    m_sel = 1;

    for (int i = 0; i < 6; i++) begin
      turn(tbl[i].rot, 0);
      $display("browse vec %0d: rot=%0d sel=%0d (exp %0d)", i, tbl[i].rot, sel, tbl[i].exp_sel);
      check($sformatf("browse vec%0d sel", i), int'(sel), tbl[i].exp_sel);
      check($sformatf("browse vec%0d editing", i), int'(editing), 0);
    end
    check_all("browse");

    btn_n = 1'b0;
    repeat (DEB - 10) @(negedge clk);
    btn_n = 1'b1;
    repeat (DEB + 5) @(negedge clk);
    $display("short press: editing=%0d", editing);
    check("short press editing", int'(editing), 0);

    btn_n = 1'b0;
    repeat (DEB - 4) @(negedge clk);
    btn_n = 1'b1;
    repeat (2) @(negedge clk);
    btn_n = 1'b0;
    repeat (DEB - 4) @(negedge clk);
    btn_n = 1'b1;
    repeat (DEB + 5) @(negedge clk);
    $display("bounced press: editing=%0d", editing);
    check("bounce editing", int'(editing), 0);

    inc(0);
    inc(0);
    check("navigate sel", int'(sel), 2);
    press();
    $display("enter edit: editing=%0d edit_val=%0d", editing, edit_val);
    check_all("enter edit");
    check("enter edit editing", int'(editing), 1);
    dec(0);
    check("dec floor", int'(edit_val), 0);
    edit_to(253);
    check("reach 253", int'(edit_val), 253);
    inc(ACCEL_WIN + 10);
    check("inc to 254", int'(edit_val), 254);
    inc(0);
    check("inc to 255", int'(edit_val), 255);
    inc(0);
    check("inc ceiling", int'(edit_val), 255);
    press();
    $display("commit: cfg2=%0d commits=%0d idx=%0d", cfg[23:16], commit_seen, commit_last_idx);
    check_all("commit");
    check("commit cfg2", int'(cfg[23:16]), 255);
    check("commit idx", commit_last_idx, 2);
    check("commit count", commit_seen, 1);

    press();
    dec(0);
    check("timeout pre edit_val", int'(edit_val), 254);
    repeat (TIMEOUT - 50) @(negedge clk);
    check("timeout not yet", int'(editing), 1);
    repeat (100) @(negedge clk);
    m_edit = 1'b0;
    m_last_dir = 0;
    $display("timeout: editing=%0d edit_val=%0d commits=%0d", editing, edit_val, commit_seen);
    check_all("timeout");
    check("timeout editing", int'(editing), 0);
    check("timeout edit_val reload", int'(edit_val), 255);
    check("timeout no commit", commit_seen, 1);

    press();
    dec(0);
    press_with_step();
    $display("press+step: sel=%0d cfg2=%0d commits=%0d", sel, cfg[23:16], commit_seen);
    check_all("press+step");
    check("press+step cfg2", int'(cfg[23:16]), 254);
    check("press+step sel", int'(sel), 2);
    check("press+step commits", commit_seen, 2);

    inc(0);
    check("accel item sel", int'(sel), 3);
    press();
    edit_to(10);
    check("accel start", int'(edit_val), 10);
    inc(ACCEL_WIN + 10);
    check("accel inc1", int'(edit_val), 11);
    inc(100);
    check("accel inc2", int'(edit_val), ACCEL ? 15 : 12);
    inc(100);
    check("accel inc3", int'(edit_val), ACCEL ? 19 : 13);
    dec(100);
    check("accel dec", int'(edit_val), ACCEL ? 18 : 12);
    inc(ACCEL_WIN + 10);
    check("accel expired", int'(edit_val), ACCEL ? 19 : 13);
    $display("accel sequence done: edit_val=%0d", edit_val);
    press();
    check_all("accel commit");

    for (int n = 0; n < 150; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 4) inc(0);
      else if (op < 8) dec(0);
      else if (op == 8) turn((m_prev + int'($urandom_range(2, RN - 2))) % RN, 0);
      else press();
      $display("rnd %0d op=%0d sel=%0d editing=%0d edit_val=%0d", n, op, sel, editing, edit_val);
      check_all($sformatf("rnd%0d", n));
    end
    if (m_edit) begin
      press();
      check_all("final commit");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
